// File: rtl/posit_pkg.sv
// Shared types for the posit datapath and the issue queue in front of it.
//
// Contents:
//   operation_e          - posit operation selector
//   roundmode_e          - rounding mode
//   issue_req_t          - one queued request at default widths
//                          {operands, op, op_mod, rnd_mode, tag}
//   ISSUE_DEPTH_DEFAULT  - default issue queue depth
package posit_pkg;

    localparam int POSIT_WIDTH_DEFAULT = 32;
    localparam int ISSUE_TAG_WIDTH_DEFAULT = 1;
    localparam int ISSUE_DEPTH_DEFAULT = 4;

    typedef enum logic [3:0] {
        FMADD    = 4'd0,
        FNMSUB   = 4'd1,
        ADD      = 4'd2,
        MUL      = 4'd3,
        DIV      = 4'd4,
        SQRT     = 4'd5,
        MINMAX   = 4'd6,
        CMP      = 4'd7,
        CLASSIFY = 4'd8,
        F2I      = 4'd9,
        I2F      = 4'd10
    } operation_e;

    typedef enum logic [2:0] {
        RNE = 3'd0,
        RTZ = 3'd1,
        RDN = 3'd2,
        RUP = 3'd3,
        RMM = 3'd4,
        DYN = 3'd7
    } roundmode_e;

    typedef struct packed {
        logic [3*POSIT_WIDTH_DEFAULT-1:0]   operands;
        operation_e                         op;
        logic                               op_mod;
        roundmode_e                         rnd_mode;
        logic [ISSUE_TAG_WIDTH_DEFAULT-1:0] tag;
    } issue_req_t;

endpackage

// File: rtl/posit_issue_fifo.sv
// Generic DEPTH-entry FIFO holding posit issue requests.
//
// Ports:
//   clk_i, rst_ni - clock, asynchronous active-low reset
//   flush         - synchronous clear of pointers and occupancy
//   push, wdata   - write one entry (caller guarantees !full)
//   pop           - drop the head entry (caller guarantees !empty)
//   rdata         - current head entry
//   empty, full   - occupancy flags
//
// Storage is reset to zero so the head payload reads as zero out of reset.
module posit_issue_fifo
    import posit_pkg::*;
#(
    parameter int  DEPTH   = ISSUE_DEPTH_DEFAULT,
    parameter type entry_t = issue_req_t
) (
    input  logic   clk_i,
    input  logic   rst_ni,
    input  logic   flush,
    input  logic   push,
    input  entry_t wdata,
    input  logic   pop,
    output entry_t rdata,
    output logic   empty,
    output logic   full
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    entry_t             mem [DEPTH];
    logic [PTR_W-1:0]   rd_ptr;
    logic [PTR_W-1:0]   wr_ptr;
    logic [CNT_W-1:0]   count;

    assign empty = (count == '0);
    assign full  = (count == CNT_W'(DEPTH));
    assign rdata = mem[rd_ptr];

    // Entry storage; a flush only discards the write, old contents are harmless.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (push && !flush) begin
            mem[wr_ptr] <= wdata;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/posit_issue_queue.sv
// Request buffer between the core and posit_top.
//
// Requests enter over req_valid_i/req_ready_o, wait in a small FIFO, and the
// head is offered to posit_top over in_valid_o/in_ready_i. Operations issued
// but not yet completed (resp_fire_i) are counted; issue stops once
// MAX_OUTSTANDING are in flight.
//
// Ports:
//   clk_i, rst_ni               - clock, asynchronous active-low reset
//   req_*                       - core request channel and payload
//   operands_o .. tag_o         - head payload toward posit_top
//   in_valid_o, in_ready_i      - issue handshake with posit_top
//   resp_fire_i                 - one completion leaving posit_top
//   flush_i                     - clears queue and credit state next edge
//   busy_o                      - queue non-empty or operations in flight
//   issue_cnt_o, stall_cnt_o    - performance counters
//
// Macro POSIT_ISSUE_PERF_EN enables the performance counters; without it both
// counter outputs are tied to zero and no counter flops exist.
module posit_issue_queue
    import posit_pkg::*;
#(
    parameter int WIDTH           = 32,
    parameter int DEPTH           = ISSUE_DEPTH_DEFAULT,
    parameter int TAG_WIDTH       = 1,
    parameter int MAX_OUTSTANDING = 2
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 req_valid_i,
    output logic                 req_ready_o,
    input  logic [3*WIDTH-1:0]   req_operands_i,
    input  operation_e           req_op_i,
    input  logic                 req_op_mod_i,
    input  roundmode_e           req_rnd_mode_i,
    input  logic [TAG_WIDTH-1:0] req_tag_i,
    output logic [3*WIDTH-1:0]   operands_o,
    output operation_e           op_o,
    output logic                 op_mod_o,
    output roundmode_e           rnd_mode_o,
    output logic [TAG_WIDTH-1:0] tag_o,
    output logic                 in_valid_o,
    input  logic                 in_ready_i,
    input  logic                 resp_fire_i,
    input  logic                 flush_i,
    output logic                 busy_o,
    output logic [31:0]          issue_cnt_o,
    output logic [31:0]          stall_cnt_o
);

    localparam int OUT_W = $clog2(MAX_OUTSTANDING + 1);

    typedef struct packed {
        logic [3*WIDTH-1:0]   operands;
        operation_e           op;
        logic                 op_mod;
        roundmode_e           rnd_mode;
        logic [TAG_WIDTH-1:0] tag;
    } req_t;

    req_t             wr_entry;
    req_t             head;
    logic             fifo_empty;
    logic             fifo_full;
    logic             push;
    logic             pop;
    logic             credit_full;
    logic             resp_take;
    logic [OUT_W-1:0] outstanding;

    always_comb begin
        wr_entry          = '0;
        wr_entry.operands = req_operands_i;
        wr_entry.op       = req_op_i;
        wr_entry.op_mod   = req_op_mod_i;
        wr_entry.rnd_mode = req_rnd_mode_i;
        wr_entry.tag      = req_tag_i;
    end

    assign credit_full = (outstanding == OUT_W'(MAX_OUTSTANDING));
    assign req_ready_o = !fifo_full && !flush_i;
    assign push        = req_valid_i && req_ready_o;
    assign in_valid_o  = !fifo_empty && !credit_full && !flush_i;
    assign pop         = in_valid_o && in_ready_i;
    // A completion with nothing in flight is spurious and must not underflow.
    assign resp_take   = resp_fire_i && (outstanding != '0);

    posit_issue_fifo #(
        .DEPTH   (DEPTH),
        .entry_t (req_t)
    ) u_fifo (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .flush  (flush_i),
        .push   (push),
        .wdata  (wr_entry),
        .pop    (pop),
        .rdata  (head),
        .empty  (fifo_empty),
        .full   (fifo_full)
    );

    // Credit counter: an issue and a completion in the same cycle cancel out.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            outstanding <= '0;
        end else if (flush_i) begin
            outstanding <= '0;
        end else if (pop && !resp_take) begin
            outstanding <= outstanding + OUT_W'(1);
        end else if (!pop && resp_take) begin
            outstanding <= outstanding - OUT_W'(1);
        end
    end

    assign operands_o = head.operands;
    assign op_o       = head.op;
    assign op_mod_o   = head.op_mod;
    assign rnd_mode_o = head.rnd_mode;
    assign tag_o      = head.tag;
    assign busy_o     = !fifo_empty || (outstanding != '0);

`ifdef POSIT_ISSUE_PERF_EN
    logic [31:0] issue_cnt;
    logic [31:0] stall_cnt;

    // Counters survive a flush; only reset clears them. A stall is any cycle
    // with queued data that does not end in an issue.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            issue_cnt <= '0;
            stall_cnt <= '0;
        end else begin
            if (pop) begin
                issue_cnt <= issue_cnt + 32'd1;
            end
            if (!fifo_empty && !pop) begin
                stall_cnt <= stall_cnt + 32'd1;
            end
        end
    end

    assign issue_cnt_o = issue_cnt;
    assign stall_cnt_o = stall_cnt;
`else
    assign issue_cnt_o = '0;
    assign stall_cnt_o = '0;
`endif

endmodule

// File: tb/tb_posit_issue_queue.sv
// Self-checking bench for posit_issue_queue at default parameters.
// A queue-based reference model tracks queued requests, in-flight credits
// and the performance counters (honours POSIT_ISSUE_PERF_EN).
module tb_posit_issue_queue;
    import posit_pkg::*;

    localparam int WIDTH     = 32;
    localparam int DEPTH     = 4;
    localparam int TAG_WIDTH = 1;
    localparam int MAX_OUT   = 2;

    typedef struct packed {
        logic [3*WIDTH-1:0]   operands;
        operation_e           op;
        logic                 op_mod;
        roundmode_e           rnd;
        logic [TAG_WIDTH-1:0] tag;
    } ref_req_t;

    logic                 clk_i;
    logic                 rst_ni;
    logic                 req_valid_i;
    logic                 req_ready_o;
    logic [3*WIDTH-1:0]   req_operands_i;
    operation_e           req_op_i;
    logic                 req_op_mod_i;
    roundmode_e           req_rnd_mode_i;
    logic [TAG_WIDTH-1:0] req_tag_i;
    logic [3*WIDTH-1:0]   operands_o;
    operation_e           op_o;
    logic                 op_mod_o;
    roundmode_e           rnd_mode_o;
    logic [TAG_WIDTH-1:0] tag_o;
    logic                 in_valid_o;
    logic                 in_ready_i;
    logic                 resp_fire_i;
    logic                 flush_i;
    logic                 busy_o;
    logic [31:0]          issue_cnt_o;
    logic [31:0]          stall_cnt_o;

    ref_req_t    model_q[$];
    int          model_out;
    int unsigned model_issue;
    int unsigned model_stall;
    int          checks;
    int          errors;

    posit_issue_queue #(
        .WIDTH           (WIDTH),
        .DEPTH           (DEPTH),
        .TAG_WIDTH       (TAG_WIDTH),
        .MAX_OUTSTANDING (MAX_OUT)
    ) dut (
        .clk_i          (clk_i),
        .rst_ni         (rst_ni),
        .req_valid_i    (req_valid_i),
        .req_ready_o    (req_ready_o),
        .req_operands_i (req_operands_i),
        .req_op_i       (req_op_i),
        .req_op_mod_i   (req_op_mod_i),
        .req_rnd_mode_i (req_rnd_mode_i),
        .req_tag_i      (req_tag_i),
        .operands_o     (operands_o),
        .op_o           (op_o),
        .op_mod_o       (op_mod_o),
        .rnd_mode_o     (rnd_mode_o),
        .tag_o          (tag_o),
        .in_valid_o     (in_valid_o),
        .in_ready_i     (in_ready_i),
        .resp_fire_i    (resp_fire_i),
        .flush_i        (flush_i),
        .busy_o         (busy_o),
        .issue_cnt_o    (issue_cnt_o),
        .stall_cnt_o    (stall_cnt_o)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    task automatic checkOutput(input string name, input logic [127:0] observed,
                               input logic [127:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("[TB] FAIL %s: observed %0h expected %0h", name, observed, expected);
        end
    endtask

    // Registered counters as the model predicts them right now.
    task automatic checkCounters();
`ifdef POSIT_ISSUE_PERF_EN
        checkOutput("issue_cnt", 128'(issue_cnt_o), 128'(model_issue));
        checkOutput("stall_cnt", 128'(stall_cnt_o), 128'(model_stall));
`else
        checkOutput("issue_cnt", 128'(issue_cnt_o), 128'(0));
        checkOutput("stall_cnt", 128'(stall_cnt_o), 128'(0));
`endif
    endtask

    // One clock cycle: drive inputs, check combinational outputs against the
    // model, advance the model by the rules of one edge, then step the clock.
    task automatic applyStimulus(input logic v, input logic [3*WIDTH-1:0] ops,
                                 input operation_e op, input logic [TAG_WIDTH-1:0] tg,
                                 input logic rdy, input logic resp, input logic fl);
        logic     exp_ready;
        logic     exp_valid;
        logic     exp_busy;
        logic     accepted;
        logic     issued;
        int       size_before;
        int       out_before;
        ref_req_t entry;
        req_valid_i    = v;
        req_operands_i = ops;
        req_op_i       = op;
        req_op_mod_i   = 1'($urandom_range(0, 1));
        req_rnd_mode_i = roundmode_e'(3'($urandom_range(0, 4)));
        req_tag_i      = tg;
        in_ready_i     = rdy;
        resp_fire_i    = resp;
        flush_i        = fl;
        #1;
        size_before = model_q.size();
        out_before  = model_out;
        exp_ready   = (size_before != DEPTH) && !fl;
        exp_valid   = (size_before != 0) && (out_before != MAX_OUT) && !fl;
        exp_busy    = (size_before != 0) || (out_before != 0);
        checkOutput("req_ready", 128'(req_ready_o), 128'(exp_ready));
        checkOutput("in_valid", 128'(in_valid_o), 128'(exp_valid));
        checkOutput("busy", 128'(busy_o), 128'(exp_busy));
        if (size_before != 0) begin
            checkOutput("operands", 128'(operands_o), 128'(model_q[0].operands));
            checkOutput("op", 128'(op_o), 128'(model_q[0].op));
            checkOutput("op_mod", 128'(op_mod_o), 128'(model_q[0].op_mod));
            checkOutput("rnd_mode", 128'(rnd_mode_o), 128'(model_q[0].rnd));
            checkOutput("tag", 128'(tag_o), 128'(model_q[0].tag));
        end
        checkCounters();
        accepted = v && exp_ready;
        issued   = exp_valid && rdy;
        if (fl) begin
            model_q.delete();
            model_out = 0;
        end else begin
            if (issued) begin
                void'(model_q.pop_front());
            end
            if (accepted) begin
                entry.operands = ops;
                entry.op       = op;
                entry.op_mod   = req_op_mod_i;
                entry.rnd      = req_rnd_mode_i;
                entry.tag      = tg;
                model_q.push_back(entry);
            end
            model_out = out_before + (issued ? 1 : 0) - ((resp && out_before > 0) ? 1 : 0);
        end
        if (issued) begin
            model_issue++;
        end
        if (size_before != 0 && !issued) begin
            model_stall++;
        end
        @(posedge clk_i);
        #1;
    endtask

    // Asynchronous reset asserted mid-cycle; outputs must clear immediately.
    task automatic doReset();
        #2;
        rst_ni      = 1'b0;
        req_valid_i = 1'b0;
        in_ready_i  = 1'b0;
        resp_fire_i = 1'b0;
        flush_i     = 1'b0;
        #1;
        checkOutput("rst_in_valid", 128'(in_valid_o), 128'(0));
        checkOutput("rst_busy", 128'(busy_o), 128'(0));
        checkOutput("rst_req_ready", 128'(req_ready_o), 128'(1));
        checkOutput("rst_operands", 128'(operands_o), 128'(0));
        checkOutput("rst_op", 128'(op_o), 128'(0));
        checkOutput("rst_tag", 128'(tag_o), 128'(0));
        checkOutput("rst_issue_cnt", 128'(issue_cnt_o), 128'(0));
        checkOutput("rst_stall_cnt", 128'(stall_cnt_o), 128'(0));
        model_q.delete();
        model_out   = 0;
        model_issue = 0;
        model_stall = 0;
        @(negedge clk_i);
        rst_ni = 1'b1;
        @(posedge clk_i);
        #1;
    endtask

    function automatic logic [3*WIDTH-1:0] randOps();
        return {$urandom, $urandom, $urandom};
    endfunction

    task automatic idle(input logic rdy, input logic resp);
        applyStimulus(1'b0, '0, ADD, 1'b0, rdy, resp, 1'b0);
    endtask

    initial begin
        checks      = 0;
        errors      = 0;
        model_out   = 0;
        model_issue = 0;
        model_stall = 0;
        rst_ni         = 1'b1;
        req_valid_i    = 1'b0;
        req_operands_i = '0;
        req_op_i       = ADD;
        req_op_mod_i   = 1'b0;
        req_rnd_mode_i = RNE;
        req_tag_i      = '0;
        in_ready_i     = 1'b0;
        resp_fire_i    = 1'b0;
        flush_i        = 1'b0;

        doReset();

        $display("[TB] single ADD issue and completion");
        applyStimulus(1'b1, {32'hA, 32'hB, 32'hC}, ADD, 1'b1, 1'b1, 1'b0, 1'b0);
        checkOutput("add_in_valid_next", 128'(in_valid_o), 128'(1));
        checkOutput("add_operands", 128'(operands_o), 128'({32'hA, 32'hB, 32'hC}));
        checkOutput("add_op", 128'(op_o), 128'(ADD));
        idle(1'b1, 1'b0);
        idle(1'b0, 1'b0);
        idle(1'b0, 1'b1);
        checkOutput("add_busy_clear", 128'(busy_o), 128'(0));

        $display("[TB] fill queue with in_ready low, then drain against credits");
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1'b1, randOps(), MUL, 1'(i), 1'b0, 1'b0, 1'b0);
        end
        checkOutput("full_req_ready", 128'(req_ready_o), 128'(0));
        applyStimulus(1'b1, randOps(), DIV, 1'b0, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) begin
            idle(1'b1, 1'b0);
        end
        checkOutput("credit_block", 128'(in_valid_o), 128'(0));
        idle(1'b1, 1'b1);
        checkOutput("credit_release_tag", 128'(tag_o), 128'(0));
        repeat (8) idle(1'b1, 1'b1);

        $display("[TB] full queue with simultaneous request and issue");
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1'b1, randOps(), FMADD, 1'(i), 1'b0, 1'b0, 1'b0);
        end
        applyStimulus(1'b1, randOps(), SQRT, 1'b1, 1'b1, 1'b1, 1'b0);
        applyStimulus(1'b1, randOps(), SQRT, 1'b0, 1'b1, 1'b1, 1'b0);
        repeat (10) idle(1'b1, 1'b1);

        $display("[TB] flush with queued and outstanding work");
        for (int i = 0; i < 5; i++) begin
            applyStimulus(1'b1, randOps(), ADD, 1'(i), 1'b1, 1'b0, 1'b0);
        end
        applyStimulus(1'b1, randOps(), MUL, 1'b1, 1'b1, 1'b1, 1'b1);
        checkOutput("flush_busy", 128'(busy_o), 128'(0));
        checkOutput("flush_in_valid", 128'(in_valid_o), 128'(0));
        idle(1'b1, 1'b0);

        $display("[TB] performance counters: 5 issues, 3 stalls");
        doReset();
        applyStimulus(1'b1, randOps(), ADD, 1'b0, 1'b0, 1'b0, 1'b0);
        repeat (3) idle(1'b0, 1'b0);
        for (int i = 0; i < 5; i++) begin
            applyStimulus(1'b1, randOps(), ADD, 1'(i), 1'b1, 1'b1, 1'b0);
        end
`ifdef POSIT_ISSUE_PERF_EN
        checkOutput("perf_issue5", 128'(issue_cnt_o), 128'(5));
        checkOutput("perf_stall3", 128'(stall_cnt_o), 128'(3));
`else
        checkOutput("perf_issue_off", 128'(issue_cnt_o), 128'(0));
        checkOutput("perf_stall_off", 128'(stall_cnt_o), 128'(0));
`endif

        $display("[TB] randomized traffic with an asynchronous reset midway");
        for (int i = 0; i < 600; i++) begin
            if (i == 300) begin
                doReset();
            end
            applyStimulus(1'($urandom_range(0, 3) != 0), randOps(),
                          operation_e'(4'($urandom_range(0, 10))), 1'($urandom_range(0, 1)),
                          1'($urandom_range(0, 2) != 0), 1'($urandom_range(0, 1)),
                          1'($urandom_range(0, 19) == 0));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
